// File: rtl/man_rx_kb.sv
// Manchester line receiver and KB frame decoder: sync hunt, 8 payload words + CRC word.
// Define MAN_RX_SUM_CHECK_EN to also require the word-7 ones'-complement sum for a good frame.
module man_rx_kb #(
  parameter int unsigned SAMPLES_PER_BIT = 8,
  parameter logic [15:0] SYNC_WORD       = 16'h0564
) (
  input  logic        clk_20MHz,
  input  logic        reset_n,
  input  logic        man_rx,
  output logic [15:0] rx_word0,
  output logic [15:0] rx_word1,
  output logic [15:0] rx_word2,
  output logic [15:0] rx_word3,
  output logic [15:0] rx_word4,
  output logic [15:0] rx_word5,
  output logic [15:0] rx_fs_cnt,
  output logic        rx_valid,
  output logic        crc_err,
  output logic        sum_err,
  output logic        man_err,
  output logic [15:0] good_cnt,
  output logic [7:0]  err_cnt
);
  localparam int unsigned WIN_LO  = (3 * SAMPLES_PER_BIT) / 4;
  localparam int unsigned WIN_HI  = (5 * SAMPLES_PER_BIT) / 4;
  localparam int unsigned PW      = $clog2(WIN_HI + 2);
  localparam logic [PW-1:0] PH_LO   = PW'(WIN_LO);
  localparam logic [PW-1:0] PH_HI   = PW'(WIN_HI);
  localparam logic [PW-1:0] PH_LOST = PW'(WIN_HI + 1);
  localparam logic [7:0]  LAST_BIT = 8'd143;
  localparam logic [15:0] CRC_POLY = 16'h3D65;

  typedef enum logic [1:0] {HUNT, DATA, CHECK} state_e;

  state_e           state_q, state_d;
  logic [2:0]       sync_q;
  logic             edge_q, lvl_q;
  logic [PW-1:0]    phase_q, phase_d;
  logic             locked_q, locked_d;
  logic             bit_ok, lost;
  logic [15:0]      win_q, win_nxt;
  logic [15:0]      shreg_q, word_nxt;
  logic [7:0]       bitcnt_q;
  logic [3:0]       widx;
  logic             word_done;
  logic [15:0]      crc_q, crc_nxt;
  logic             crc_fb;
  logic [6:0][15:0] wbuf_q, wout_q;
  logic             crc_ok, sum_ok;
  logic             valid_d, crc_e_d, sum_e_d, man_e_d, err_ev;
  logic             rx_valid_q, crc_err_q, man_err_q;
  logic [15:0]      good_cnt_q;
  logic [7:0]       err_cnt_q;

  // Two synchronizer flops followed by the edge register; lvl_q is the level after the edge.
  always_ff @(posedge clk_20MHz) begin
    if (!reset_n) begin
      sync_q <= '0;
      edge_q <= 1'b0;
      lvl_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], man_rx};
      edge_q <= sync_q[1] ^ sync_q[2];
      lvl_q  <= sync_q[1];
    end
  end

  // phase_q counts cycles since the last accepted mid-bit edge; unlocked, any edge is taken.
  always_comb begin
    bit_ok   = edge_q && (!locked_q || (phase_q >= PH_LO && phase_q <= PH_HI));
    lost     = locked_q && (phase_q == PH_LOST);
    locked_d = locked_q;
    phase_d  = phase_q;
    if (bit_ok) begin
      locked_d = 1'b1;
      phase_d  = PW'(1);
    end else begin
      if (lost) locked_d = 1'b0;
      if (phase_q != PH_LOST) phase_d = phase_q + 1'b1;
    end
  end

  always_ff @(posedge clk_20MHz) begin
    if (!reset_n) begin
      phase_q  <= '0;
      locked_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      locked_q <= locked_d;
    end
  end

  assign win_nxt   = {win_q[14:0], lvl_q};
  assign word_nxt  = {shreg_q[14:0], lvl_q};
  assign widx      = bitcnt_q[7:4];
  assign word_done = bit_ok && (state_q == DATA) && (bitcnt_q[3:0] == 4'hF);
  assign crc_fb    = lvl_q ^ crc_q[15];
  assign crc_nxt   = {crc_q[14:0], 1'b0} ^ (crc_fb ? CRC_POLY : 16'h0000);
  assign crc_ok    = (shreg_q == ~crc_q);

  // FSM: state register
  always_ff @(posedge clk_20MHz) begin
    if (!reset_n) state_q <= HUNT;
    else          state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      HUNT:    if (bit_ok && win_nxt == SYNC_WORD) state_d = DATA;
      DATA:    if (lost) state_d = HUNT;
               else if (bit_ok && bitcnt_q == LAST_BIT) state_d = CHECK;
      CHECK:   state_d = HUNT;
      default: state_d = HUNT;
    endcase
  end

  // FSM: outputs (registered one cycle later as the pulses)
  always_comb begin
    valid_d = 1'b0;
    crc_e_d = 1'b0;
    sum_e_d = 1'b0;
    man_e_d = 1'b0;
    unique case (state_q)
      DATA:  man_e_d = lost;
      CHECK: begin
        valid_d = crc_ok && sum_ok;
        crc_e_d = !crc_ok;
        sum_e_d = !sum_ok;
      end
      default: ;
    endcase
  end

  assign err_ev = crc_e_d | sum_e_d | man_e_d;

  // Frame datapath: sync window, word shifter, bit counter, CRC and word buffer.
  always_ff @(posedge clk_20MHz) begin
    if (!reset_n) begin
      win_q    <= '0;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      crc_q    <= '0;
      wbuf_q   <= '0;
    end else begin
      unique case (state_q)
        HUNT: begin
          bitcnt_q <= '0;
          crc_q    <= '0;
          if (lost)        win_q <= '0;
          else if (bit_ok) win_q <= win_nxt;
        end
        DATA: begin
          if (lost) win_q <= '0;
          if (bit_ok) begin
            shreg_q  <= word_nxt;
            bitcnt_q <= bitcnt_q + 8'd1;
            if (bitcnt_q < 8'd128) crc_q <= crc_nxt;
            if (word_done && widx < 4'd7) wbuf_q[widx[2:0]] <= word_nxt;
          end
        end
        default: win_q <= '0;
      endcase
    end
  end

`ifdef MAN_RX_SUM_CHECK_EN
  logic [15:0] sum_q, w7_q;
  logic        sum_err_q;

  assign sum_ok = (w7_q == ~sum_q);

  always_ff @(posedge clk_20MHz) begin
    if (!reset_n) begin
      sum_q     <= '0;
      w7_q      <= '0;
      sum_err_q <= 1'b0;
    end else begin
      sum_err_q <= sum_e_d;
      if (state_q == HUNT) sum_q <= '0;
      else if (word_done) begin
        if (widx < 4'd7)       sum_q <= sum_q + word_nxt;
        else if (widx == 4'd7) w7_q  <= word_nxt;
      end
    end
  end

  assign sum_err = sum_err_q;
`else
  assign sum_ok  = 1'b1;
  assign sum_err = 1'b0;
`endif

  // Output registers: words only move on a good frame.
  always_ff @(posedge clk_20MHz) begin
    if (!reset_n) begin
      wout_q     <= '0;
      rx_valid_q <= 1'b0;
      crc_err_q  <= 1'b0;
      man_err_q  <= 1'b0;
      good_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      rx_valid_q <= valid_d;
      crc_err_q  <= crc_e_d;
      man_err_q  <= man_e_d;
      if (valid_d) begin
        wout_q     <= wbuf_q;
        good_cnt_q <= good_cnt_q + 16'd1;
      end
      if (err_ev && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign rx_word0  = wout_q[0];
  assign rx_word1  = wout_q[1];
  assign rx_word2  = wout_q[2];
  assign rx_word3  = wout_q[3];
  assign rx_word4  = wout_q[4];
  assign rx_word5  = wout_q[5];
  assign rx_fs_cnt = wout_q[6];
  assign rx_valid  = rx_valid_q;
  assign crc_err   = crc_err_q;
  assign man_err   = man_err_q;
  assign good_cnt  = good_cnt_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_man_rx_kb.sv
// Directed bench for man_rx_kb: good/bad frames, lost lock, mid-frame reset, back-to-back.
`timescale 1ns/1ps
module tb_man_rx_kb;
  logic        clk_20MHz = 1'b0;
  logic        reset_n   = 1'b0;
  logic        man_rx    = 1'b1;
  logic [15:0] rx_word0, rx_word1, rx_word2, rx_word3, rx_word4, rx_word5, rx_fs_cnt, good_cnt;
  logic        rx_valid, crc_err, sum_err, man_err;
  logic [7:0]  err_cnt;

  int  n_tests = 0, n_fail = 0;
  int  n_valid = 0, n_crc = 0, n_sum = 0, n_man = 0, n_overlap = 0;
  time t_mid, t_last, t_valid, t_crc;
  logic [15:0] fw  [0:9];
  logic [15:0] pay [0:6];

  always #25 clk_20MHz = ~clk_20MHz;

  man_rx_kb dut (
    .clk_20MHz(clk_20MHz), .reset_n(reset_n), .man_rx(man_rx),
    .rx_word0(rx_word0), .rx_word1(rx_word1), .rx_word2(rx_word2),
    .rx_word3(rx_word3), .rx_word4(rx_word4), .rx_word5(rx_word5),
    .rx_fs_cnt(rx_fs_cnt), .rx_valid(rx_valid), .crc_err(crc_err),
    .sum_err(sum_err), .man_err(man_err), .good_cnt(good_cnt), .err_cnt(err_cnt)
  );

  // Pulse monitor, sampled on the falling edge.
  always @(negedge clk_20MHz) begin
    if (rx_valid) begin n_valid++; t_valid = $time; end
    if (crc_err)  begin n_crc++;   t_crc   = $time; end
    if (sum_err)  n_sum++;
    if (man_err)  n_man++;
    if (rx_valid && (crc_err || sum_err || man_err)) n_overlap++;
  end

  task automatic send_bit(input logic b, input int spb);
    man_rx = ~b;
    repeat (spb / 2) @(negedge clk_20MHz);
    man_rx = b;
    t_mid  = $time;
    repeat (spb - spb / 2) @(negedge clk_20MHz);
  endtask

  task automatic send_word(input logic [15:0] w, input int spb);
    for (int i = 15; i >= 0; i--) send_bit(w[i], spb);
  endtask

  task automatic send_idle(input int n, input int spb);
    for (int i = 0; i < n; i++) send_bit(1'b1, spb);
  endtask

  task automatic send_frame(input int spb);
    for (int k = 0; k < 10; k++) send_word(fw[k], spb);
    t_last = t_mid;
  endtask

  function automatic logic [15:0] calc_crc();
    logic [15:0] c;
    logic        fb;
    c = 16'h0000;
    for (int k = 1; k <= 8; k++)
      for (int i = 15; i >= 0; i--) begin
        fb = fw[k][i] ^ c[15];
        c  = {c[14:0], 1'b0} ^ (fb ? 16'h3D65 : 16'h0000);
      end
    return c;
  endfunction

  task automatic build_frame();
    logic [15:0] s;
    s = 16'h0000;
    fw[0] = 16'h0564;
    for (int k = 0; k < 7; k++) begin
      fw[k+1] = pay[k];
      s       = s + pay[k];
    end
    fw[8] = ~s;
    fw[9] = ~calc_crc();
  endtask

  task automatic pay_default();
    pay = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666, 16'h0007};
  endtask

  task automatic pulse_reset();
    @(negedge clk_20MHz); reset_n = 1'b0;
    @(negedge clk_20MHz); reset_n = 1'b1;
  endtask

  task automatic test_reset();
    man_rx = 1'b1; reset_n = 1'b0;
    repeat (4) @(negedge clk_20MHz);
    n_tests++; if ({rx_word0, rx_word1, rx_word2, rx_word3, rx_word4, rx_word5, rx_fs_cnt} !== 112'h0) begin
      n_fail++; $display("FAIL reset_words: got %h exp 0", {rx_word0, rx_word1, rx_word2, rx_word3, rx_word4, rx_word5, rx_fs_cnt}); end
    n_tests++; if ({rx_valid, crc_err, sum_err, man_err} !== 4'h0) begin
      n_fail++; $display("FAIL reset_flags: got %b exp 0000", {rx_valid, crc_err, sum_err, man_err}); end
    n_tests++; if ({good_cnt, err_cnt} !== 24'h0) begin
      n_fail++; $display("FAIL reset_cnts: got %h/%h exp 0/0", good_cnt, err_cnt); end
    reset_n = 1'b1;
  endtask

  task automatic test_good_frame();
    int v0;
    v0 = n_valid;
    send_idle(32, 8);
    pay_default(); build_frame();
    send_frame(8); send_idle(4, 8);
    n_tests++; if (n_valid - v0 !== 1) begin n_fail++; $display("FAIL good_valid_cnt: got %0d exp 1", n_valid - v0); end
    n_tests++; if (t_valid - t_last !== 250) begin n_fail++; $display("FAIL good_latency: got %0t exp 250", t_valid - t_last); end
    n_tests++; if ({rx_word0, rx_word1, rx_word2} !== 48'h1111_2222_3333) begin
      n_fail++; $display("FAIL good_w012: got %h %h %h exp 1111 2222 3333", rx_word0, rx_word1, rx_word2); end
    n_tests++; if ({rx_word3, rx_word4, rx_word5} !== 48'h4444_5555_6666) begin
      n_fail++; $display("FAIL good_w345: got %h %h %h exp 4444 5555 6666", rx_word3, rx_word4, rx_word5); end
    n_tests++; if (rx_fs_cnt !== 16'h0007) begin n_fail++; $display("FAIL good_fs_cnt: got %h exp 0007", rx_fs_cnt); end
    n_tests++; if (good_cnt !== 16'd1 || err_cnt !== 8'd0) begin
      n_fail++; $display("FAIL good_cnts: got %0d/%0d exp 1/0", good_cnt, err_cnt); end
  endtask

  task automatic test_crc_err();
    int v0, c0, s0;
    v0 = n_valid; c0 = n_crc; s0 = n_sum;
    pay_default(); build_frame();
    fw[9] = fw[9] ^ 16'h0001;
    send_frame(8); send_idle(4, 8);
    n_tests++; if (n_crc - c0 !== 1) begin n_fail++; $display("FAIL crc_pulse: got %0d exp 1", n_crc - c0); end
    n_tests++; if (t_crc - t_last !== 250) begin n_fail++; $display("FAIL crc_latency: got %0t exp 250", t_crc - t_last); end
    n_tests++; if (n_valid - v0 !== 0 || n_sum - s0 !== 0) begin
      n_fail++; $display("FAIL crc_other: valid %0d sum %0d exp 0 0", n_valid - v0, n_sum - s0); end
    n_tests++; if (err_cnt !== 8'd1 || good_cnt !== 16'd1) begin
      n_fail++; $display("FAIL crc_cnts: got %0d/%0d exp err 1 good 1", err_cnt, good_cnt); end
    n_tests++; if (rx_word0 !== 16'h1111 || rx_fs_cnt !== 16'h0007) begin
      n_fail++; $display("FAIL crc_hold: got %h %h exp 1111 0007", rx_word0, rx_fs_cnt); end
  endtask

  task automatic test_sum_err();
    int v0, c0, s0;
    v0 = n_valid; c0 = n_crc; s0 = n_sum;
    pay_default(); build_frame();
    fw[4] = 16'h4445;
    fw[9] = ~calc_crc();
    send_frame(8); send_idle(4, 8);
    n_tests++; if (n_crc - c0 !== 0) begin n_fail++; $display("FAIL sum_crc: got %0d exp 0", n_crc - c0); end
`ifdef MAN_RX_SUM_CHECK_EN
    n_tests++; if (n_sum - s0 !== 1 || n_valid - v0 !== 0) begin
      n_fail++; $display("FAIL sum_pulse: sum %0d valid %0d exp 1 0", n_sum - s0, n_valid - v0); end
    n_tests++; if (err_cnt !== 8'd2 || rx_word3 !== 16'h4444) begin
      n_fail++; $display("FAIL sum_state: err %0d w3 %h exp 2 4444", err_cnt, rx_word3); end
`else
    n_tests++; if (n_sum - s0 !== 0 || n_valid - v0 !== 1) begin
      n_fail++; $display("FAIL sum_pulse: sum %0d valid %0d exp 0 1", n_sum - s0, n_valid - v0); end
    n_tests++; if (err_cnt !== 8'd1 || good_cnt !== 16'd2 || rx_word3 !== 16'h4445) begin
      n_fail++; $display("FAIL sum_state: err %0d good %0d w3 %h exp 1 2 4445", err_cnt, good_cnt, rx_word3); end
`endif
  endtask

  task automatic test_lost_lock();
    int v0, m0;
    logic [7:0]  e0;
    logic [15:0] g0;
    v0 = n_valid; m0 = n_man; e0 = err_cnt; g0 = good_cnt;
    pay_default(); build_frame();
    for (int k = 0; k < 3; k++) send_word(fw[k], 8);
    for (int i = 15; i > 12; i--) send_bit(fw[3][i], 8);
    man_rx = 1'b0;
    repeat (12) @(negedge clk_20MHz);
    send_idle(20, 8);
    n_tests++; if (n_man - m0 !== 1) begin n_fail++; $display("FAIL lost_man_err: got %0d exp 1", n_man - m0); end
    n_tests++; if (err_cnt !== e0 + 8'd1) begin n_fail++; $display("FAIL lost_err_cnt: got %0d exp %0d", err_cnt, e0 + 8'd1); end
    pay = '{16'hA5A5, 16'h5A5A, 16'h0F0F, 16'hF0F0, 16'h00FF, 16'hFF00, 16'h0008};
    build_frame(); send_frame(8); send_idle(4, 8);
    n_tests++; if (n_valid - v0 !== 1 || good_cnt !== g0 + 16'd1) begin
      n_fail++; $display("FAIL lost_recover: valid %0d good %0d exp 1 %0d", n_valid - v0, good_cnt, g0 + 16'd1); end
    n_tests++; if (rx_word0 !== 16'hA5A5 || rx_word5 !== 16'hFF00 || rx_fs_cnt !== 16'h0008) begin
      n_fail++; $display("FAIL lost_words: got %h %h %h exp a5a5 ff00 0008", rx_word0, rx_word5, rx_fs_cnt); end
  endtask

  task automatic test_reset_mid();
    int v0, c0, s0, m0;
    pay_default(); build_frame();
    for (int k = 0; k < 5; k++) send_word(fw[k], 8);
    for (int i = 15; i > 10; i--) send_bit(fw[5][i], 8);
    pulse_reset();
    n_tests++; if ({rx_word0, rx_word3, rx_fs_cnt, good_cnt, err_cnt} !== 72'h0) begin
      n_fail++; $display("FAIL rstmid_zero: got %h %h %h %h %h exp 0", rx_word0, rx_word3, rx_fs_cnt, good_cnt, err_cnt); end
    v0 = n_valid; c0 = n_crc; s0 = n_sum; m0 = n_man;
    send_idle(20, 8);
    n_tests++; if (n_crc - c0 + n_sum - s0 + n_man - m0 !== 0 || err_cnt !== 8'd0) begin
      n_fail++; $display("FAIL rstmid_noerr: pulses %0d err %0d exp 0 0", n_crc - c0 + n_sum - s0 + n_man - m0, err_cnt); end
    pay = '{16'h0123, 16'h4567, 16'h89AB, 16'hCDEF, 16'h1357, 16'h2468, 16'h000A};
    build_frame(); send_frame(8); send_idle(4, 8);
    n_tests++; if (n_valid - v0 !== 1 || good_cnt !== 16'd1) begin
      n_fail++; $display("FAIL rstmid_recover: valid %0d good %0d exp 1 1", n_valid - v0, good_cnt); end
    n_tests++; if (rx_word2 !== 16'h89AB || rx_fs_cnt !== 16'h000A) begin
      n_fail++; $display("FAIL rstmid_words: got %h %h exp 89ab 000a", rx_word2, rx_fs_cnt); end
  endtask

  task automatic test_back_to_back();
    int v0, c0, m0;
    pulse_reset();
    v0 = n_valid; c0 = n_crc; m0 = n_man;
    send_idle(20, 9);
    pay_default(); build_frame(); send_frame(9);
    send_idle(1, 9);
    pay = '{16'hB0B0, 16'hC1C1, 16'hD2D2, 16'hE3E3, 16'hF4F4, 16'h0505, 16'h0009};
    build_frame(); send_frame(9); send_idle(4, 9);
    n_tests++; if (n_valid - v0 !== 2 || good_cnt !== 16'd2) begin
      n_fail++; $display("FAIL b2b_valid: valid %0d good %0d exp 2 2", n_valid - v0, good_cnt); end
    n_tests++; if (n_crc - c0 + n_man - m0 !== 0 || err_cnt !== 8'd0) begin
      n_fail++; $display("FAIL b2b_err: pulses %0d err %0d exp 0 0", n_crc - c0 + n_man - m0, err_cnt); end
    n_tests++; if (rx_word0 !== 16'hB0B0 || rx_word4 !== 16'hF4F4 || rx_fs_cnt !== 16'h0009) begin
      n_fail++; $display("FAIL b2b_words: got %h %h %h exp b0b0 f4f4 0009", rx_word0, rx_word4, rx_fs_cnt); end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_crc_err();
    test_sum_err();
    test_lost_lock();
    test_reset_mid();
    test_back_to_back();
    n_tests++; if (n_overlap !== 0) begin n_fail++; $display("FAIL flag_overlap: got %0d exp 0", n_overlap); end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
